// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the stopwatch display path:
//               scan state, digit index type and the active-low segment
//               patterns used for "all off" and "dash".
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

   // Per-slot scan phase: anodes dark (BLANK) or one anode lit (DRIVE)
   typedef enum logic [0:0] {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   // Selects one of the four display digits
   typedef logic [1:0] digit_idx_t;

   // Segment order {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [3:0] AN_OFF   = 4'hF;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg
// Description : Combinational BCD to active-low seven-segment decoder.
//               Non-decimal codes 10..15 render as a dash.
// Ports       : bcd [3:0] - digit value in
//               seg [6:0] - {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = SEG_DASH;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/stopwatch_display.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_display
// Description : Time-multiplexed four-digit seven-segment driver. Digits are
//               snapshotted once per scan frame, decoded to active-low
//               segments and scanned with a blank gap at the start of each
//               digit slot to suppress ghosting.
// Ports       : clock          - system clock
//               reset          - asynchronous, active-high
//               d0..d3 [3:0]   - BCD digits (d0 rightmost)
//               lap            - hold the snapshot at the frame boundary
//               an  [3:0]      - anodes, active-low
//               seg [6:0]      - {g,f,e,d,c,b,a}, active-low
//               dp             - decimal point, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_display
   import stopwatch_pkg::*;
#(
   parameter int         SCAN_DIV     = 100_000,
   parameter int         BLANK_CYCLES = 1_000,
   parameter logic [3:0] DP_MASK      = 4'b0010,
   parameter bit         LZB          = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic       lap,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int                CNT_W     = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_DRIVE = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   digit_idx_t       idx_q, idx_d;
   logic [3:0][3:0]  snap_q, snap_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;

   scan_state_t      state;
   logic             slot_end;
   logic             frame_end;
   logic             lz_blank;
   logic [3:0]       digit_sel;
   logic [6:0]       digit_seg;

   // Single decoder shared by all slots, fed from the current slot's digit
   assign digit_sel = snap_q[idx_q];

   bcd_to_seg u_dec (
      .bcd (digit_sel),
      .seg (digit_seg)
   );

   always_comb begin
      slot_end  = (cnt_q == CNT_LAST);
      frame_end = slot_end && (idx_q == 2'd3);

      cnt_d = slot_end ? '0 : cnt_q + 1'b1;
      idx_d = slot_end ? idx_q + 1'b1 : idx_q;

      // Latch all four digits together so a frame never mixes old and new
      snap_d = snap_q;
      if (frame_end && !lap) begin
         snap_d = {d3, d2, d1, d0};
      end

      state    = (cnt_q < CNT_DRIVE) ? BLANK : DRIVE;
      lz_blank = LZB && (idx_q == 2'd3) && (digit_sel == 4'd0);

      // Segments only ever change together with the anode going dark or
      // lighting, since they are forced off throughout the blank phase
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (state == DRIVE && !lz_blank) begin
         an_d[idx_q] = 1'b0;
         seg_d       = digit_seg;
         dp_d        = ~DP_MASK[idx_q];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         snap_q <= '0;
         an_q   <= AN_OFF;
         seg_q  <= SEG_OFF;
         dp_q   <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         snap_q <= snap_d;
         an_q   <= an_d;
         seg_q  <= seg_d;
         dp_q   <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
`default_nettype wire
